// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_transmitter
//  Description : 8N1 UART serializer. Accepts a byte when TX_EN is high in
//                IDLE, then shifts out start bit, eight data bits LSB first
//                and a stop bit, each held for CLKS_PER_BIT clocks.
//                All outputs are registered; reset is asynchronous, active low.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       UART_TX,
  output logic       TX_STATUS,
  output logic       TX_DONE
);

  // Counter only needs to reach CLKS_PER_BIT-1; guard the degenerate width.
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic [7:0]       shift;
  logic [7:0]       shift_nxt;
  logic             tx_nxt;
  logic             status_nxt;
  logic             done_nxt;
  logic             bit_wrap;

  // End of the current bit period.
  assign bit_wrap = (bit_cnt == CNT_LAST);

  // State and all datapath/output registers; outputs are registered so that
  // no input reaches UART_TX, TX_STATUS or TX_DONE combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= CNT_ZERO;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      UART_TX   <= 1'b1;
      TX_STATUS <= 1'b1;
      TX_DONE   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift     <= shift_nxt;
      UART_TX   <= tx_nxt;
      TX_STATUS <= status_nxt;
      TX_DONE   <= done_nxt;
    end
  end

  // Next-state and next-output logic. Output values are computed one cycle
  // ahead so that each register changes exactly at the bit boundary.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    tx_nxt      = UART_TX;
    status_nxt  = TX_STATUS;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        tx_nxt      = 1'b1;
        status_nxt  = 1'b1;
        bit_cnt_nxt = CNT_ZERO;
        bit_idx_nxt = 3'd0;
        if (TX_EN) begin
          // Byte is captured here; later TX_DATA changes are irrelevant.
          shift_nxt  = TX_DATA;
          state_nxt  = START;
          tx_nxt     = 1'b0;
          status_nxt = 1'b0;
        end
      end

      START: begin
        status_nxt = 1'b0;
        if (bit_wrap) begin
          bit_cnt_nxt = CNT_ZERO;
          state_nxt   = DATA;
          tx_nxt      = shift[0];
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_ONE;
        end
      end

      DATA: begin
        status_nxt = 1'b0;
        if (bit_wrap) begin
          bit_cnt_nxt = CNT_ZERO;
          bit_idx_nxt = bit_idx + 3'd1;
          shift_nxt   = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            // shift[1] becomes shift[0] this edge: it is the next bit out.
            tx_nxt = shift[1];
          end
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_ONE;
        end
      end

      STOP: begin
        status_nxt = 1'b0;
        tx_nxt     = 1'b1;
        if (bit_wrap) begin
          bit_cnt_nxt = CNT_ZERO;
          state_nxt   = IDLE;
          status_nxt  = 1'b1;
          done_nxt    = 1'b1;
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_ONE;
        end
      end

      default: begin
        // Any corrupted encoding recovers to a clean idle line.
        state_nxt   = IDLE;
        bit_cnt_nxt = CNT_ZERO;
        bit_idx_nxt = 3'd0;
        shift_nxt   = 8'd0;
        tx_nxt      = 1'b1;
        status_nxt  = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_transmitter
//  Description : Directed self-checking bench for uart_transmitter at
//                CLKS_PER_BIT=4 (instance a) and CLKS_PER_BIT=2 (instance b).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

  logic       clk;
  logic       reset;
  logic [7:0] data_a, data_b;
  logic       en_a, en_b;
  logic       tx_a, st_a, dn_a;
  logic       tx_b, st_b, dn_b;

  int total = 0;
  int bad   = 0;

  logic tx_s [0:255];
  logic st_s [0:255];
  logic dn_s [0:255];

  uart_transmitter #(.CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .reset(reset), .TX_DATA(data_a), .TX_EN(en_a),
    .UART_TX(tx_a), .TX_STATUS(st_a), .TX_DONE(dn_a)
  );

  uart_transmitter #(.CLKS_PER_BIT(2)) dut_b (
    .clk(clk), .reset(reset), .TX_DATA(data_b), .TX_EN(en_b),
    .UART_TX(tx_b), .TX_STATUS(st_b), .TX_DONE(dn_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Record n negedge samples from one instance; optionally drop TX_EN,
  // change TX_DATA, or pulse TX_EN at given sample indices.
  task automatic capture(input bit sel_b, input int n, input int drop_at,
                         input int chg_at, input logic [7:0] chg_data,
                         input int pulse_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_s[i] = sel_b ? tx_b : tx_a;
      st_s[i] = sel_b ? st_b : st_a;
      dn_s[i] = sel_b ? dn_b : dn_a;
      if (i == drop_at) begin
        if (sel_b) en_b = 1'b0; else en_a = 1'b0;
      end
      if (i == chg_at) begin
        if (sel_b) data_b = chg_data; else data_a = chg_data;
      end
      if (i == pulse_at) begin
        if (sel_b) en_b = 1'b1; else en_a = 1'b1;
      end
      if (i == pulse_at + 1) begin
        if (sel_b) en_b = 1'b0; else en_a = 1'b0;
      end
    end
  endtask

  function automatic int count_done(input int from, input int to);
    int c = 0;
    for (int i = from; i <= to; i++) if (dn_s[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_tx_low(input int from, input int to);
    int c = 0;
    for (int i = from; i <= to; i++) if (tx_s[i] !== 1'b1) c++;
    return c;
  endfunction

  function automatic int count_status_high(input int from, input int to);
    int c = 0;
    for (int i = from; i <= to; i++) if (st_s[i] !== 1'b0) c++;
    return c;
  endfunction

  // Frame starting at sample base: start 0, d LSB first, stop 1, each held
  // cpb samples; then TX_DONE and TX_STATUS high in the following sample.
  task automatic check_frame(input int base, input int cpb, input logic [7:0] d, input string tag);
    logic        eb;
    logic [31:0] g, e;
    for (int b = 0; b < 10; b++) begin
      eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
      g = '0;
      e = '0;
      for (int k = 0; k < cpb; k++) begin
        g[k] = tx_s[base + b*cpb + k];
        e[k] = eb;
      end
      check_eq($sformatf("%s_bit%0d", tag, b), g, e);
    end
    check_eq({tag, "_busy"}, count_status_high(base, base + 10*cpb - 1), 0);
    check_eq({tag, "_nodone_in_frame"}, count_done(base, base + 10*cpb - 1), 0);
    check_eq({tag, "_done"}, {31'd0, dn_s[base + 10*cpb]}, 1);
    check_eq({tag, "_ready"}, {31'd0, st_s[base + 10*cpb]}, 1);
  endtask

  int viol;

  initial begin
    reset  = 1'b0;
    en_a   = 1'b0;
    en_b   = 1'b0;
    data_a = 8'h00;
    data_b = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_tx_a", {31'd0, tx_a}, 1);
    check_eq("rst_status_a", {31'd0, st_a}, 1);
    check_eq("rst_done_a", {31'd0, dn_a}, 0);
    check_eq("rst_tx_b", {31'd0, tx_b}, 1);
    reset = 1'b1;

    // Idle with TX_EN low for 100 cycles
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || st_a !== 1'b1 || dn_a !== 1'b0) viol++;
    end
    check_eq("idle_hold", viol, 0);

    // Single frame 8'hA5 at 4 clocks per bit
    data_a = 8'hA5; en_a = 1'b1;
    capture(1'b0, 45, 0, -10, 8'h00, -10);
    check_frame(0, 4, 8'hA5, "a5");
    check_eq("a5_done_count", count_done(0, 44), 1);

    // Back-to-back 8'h00 then 8'hFF with TX_EN held
    data_a = 8'h00; en_a = 1'b1;
    capture(1'b0, 95, 41, 0, 8'hFF, -10);
    check_frame(0, 4, 8'h00, "b2b0");
    check_eq("b2b_gap_idle", {31'd0, tx_s[40]}, 1);
    check_frame(41, 4, 8'hFF, "b2b1");
    check_eq("b2b_done_count", count_done(0, 94), 2);
    check_eq("b2b_tail_idle", count_tx_low(82, 94), 0);

    // TX_EN pulse and TX_DATA change during DATA must not disturb the frame
    data_a = 8'hC3; en_a = 1'b1;
    capture(1'b0, 70, 0, 15, 8'h0F, 15);
    check_frame(0, 4, 8'hC3, "poke");
    check_eq("poke_done_count", count_done(0, 69), 1);
    check_eq("poke_no_extra", count_tx_low(41, 69), 0);

    // Reset during bit 3 of 8'h3C
    data_a = 8'h3C; en_a = 1'b1;
    capture(1'b0, 18, 0, -10, 8'h00, -10);
    check_eq("abort_pre_start", {31'd0, tx_s[2]}, 0);
    check_eq("abort_pre_bit3", {31'd0, tx_s[16]}, 1);
    reset = 1'b0;
    #1;
    check_eq("abort_tx", {31'd0, tx_a}, 1);
    check_eq("abort_status", {31'd0, st_a}, 1);
    check_eq("abort_done", {31'd0, dn_a}, 0);
    viol = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dn_a !== 1'b0 || tx_a !== 1'b1) viol++;
    end
    check_eq("abort_hold", viol, 0);
    reset = 1'b1;
    capture(1'b0, 50, -10, -10, 8'h00, -10);
    check_eq("abort_no_resume_tx", count_tx_low(0, 49), 0);
    check_eq("abort_no_done", count_done(0, 49), 0);

    data_a = 8'h81; en_a = 1'b1;
    capture(1'b0, 45, 0, -10, 8'h00, -10);
    check_frame(0, 4, 8'h81, "after_rst");

    // 8'h55 at 2 clocks per bit
    data_b = 8'h55; en_b = 1'b1;
    capture(1'b1, 25, 0, -10, 8'h00, -10);
    check_frame(0, 2, 8'h55, "c2");
    check_eq("c2_done_count", count_done(0, 24), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
